div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits, legal range 8..64.
REQ-002 SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have input rst, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 SHALL have input signed_div_i, 1 bit: 1 selects two's-complement division, 0 selects unsigned.
REQ-005 SHALL have input opdata1_i, WIDTH bits: dividend.
REQ-006 SHALL have input opdata2_i, WIDTH bits: divisor.
REQ-007 SHALL have input start_i, 1 bit: level request, held high by the EX stage until ready_o is seen.
REQ-008 SHALL have input annul_i, 1 bit: pipeline flush; cancels any operation in progress.
REQ-009 SHALL have output result_o, 2*WIDTH bits: {remainder, quotient}.
REQ-010 SHALL have output ready_o, 1 bit: result_o is valid.
REQ-011 SHALL have output busy_o, 1 bit: division in progress; EX ORs it into stallreq.

Function
REQ-012 SHALL implement the states DIV_FREE, DIV_BY_ZERO, DIV_ON and DIV_END.
REQ-013 DIV_FREE with start_i=1, annul_i=0 and opdata2_i=0 SHALL go to DIV_BY_ZERO.
REQ-014 DIV_FREE with start_i=1, annul_i=0 and opdata2_i≠0 SHALL go to DIV_ON, clear the counter, and latch the operand magnitudes and signs.
REQ-015 In signed mode, the magnitude of a negative operand SHALL be its two's complement; unsigned mode SHALL use operands unmodified.
REQ-016 DIV_ON SHALL produce one quotient bit per cycle by restoring shift-subtract over a (2*WIDTH+1)-bit working register.
REQ-017 The iteration count SHALL be exactly WIDTH; the counter width is clog2(WIDTH+1).
REQ-018 After the final iteration, DIV_ON SHALL apply sign correction and go to DIV_END.
REQ-019 Signed sign correction: quotient negated iff operand signs differ; remainder negated iff dividend negative.
REQ-020 Latency: ready_o SHALL rise WIDTH+1 cycles after the first cycle start_i is sampled high in DIV_FREE.
REQ-021 DIV_BY_ZERO SHALL go to DIV_END on the next cycle with result 0, so ready_o rises 2 cycles after start.
REQ-022 DIV_END SHALL hold ready_o=1 and result_o stable while start_i=1.
REQ-023 DIV_END with start_i=0 SHALL return to DIV_FREE, clearing ready_o and result_o.
REQ-024 annul_i=1 in DIV_ON or DIV_BY_ZERO SHALL return to DIV_FREE next cycle; ready_o never asserts for that operation.
REQ-025 annul_i takes priority over start_i in every state.
REQ-026 A new operation SHALL be accepted only from DIV_FREE; start_i held high through DIV_END does not restart.
REQ-027 Signed overflow (most-negative / -1) SHALL yield quotient = most-negative and remainder = 0, without error.
REQ-028 busy_o SHALL be 1 in DIV_ON and DIV_BY_ZERO, 0 otherwise.
REQ-029 Outputs SHALL be registered; no combinational path from inputs to result_o or ready_o.

Reset
REQ-030 rst=0 at a clock edge SHALL force DIV_FREE with ready_o=0, busy_o=0, result_o=0 and counter=0, regardless of the current state.
REQ-031 Reset mid-operation SHALL discard partial results; the first start after reset behaves per REQ-013/014.

Structure
REQ-032 State encodings (DivFree, DivByZero, DivOn, DivEnd) and the DivResultReady/NotReady and DivStart/Stop constants SHALL live in the shared defines file.
REQ-033 The one-bit compare/subtract/shift step SHALL be a combinational sub-module div_step, parametrised by WIDTH.
REQ-034 The top level SHALL contain only the FSM, counter, operand latches and sign correction.

Verification (WIDTH=32)
REQ-035 Unsigned 100/7 -> result_o={2,14}, ready_o at cycle 33, busy_o high cycles 1-32.
REQ-036 Signed 0xFFFFFFF9 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-037 Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-038 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-039 Divisor 0 -> result 0, ready_o at cycle 2; after start_i drops, returns to DIV_FREE.
REQ-040 annul_i at cycle 10 of 100/7 -> ready_o stays 0 and state is DIV_FREE at cycle 11; an immediate restart of 100/7 completes correctly. Repeat with rst=0 at cycle 10: same response.

Source files
------------

// File: rtl/div_unit_pkg.sv
// ============================================================================
// Module  : div_unit_pkg
// Purpose : Shared state encodings and handshake constants for div_unit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

`default_nettype wire

// File: rtl/div_unit_step.sv
// ============================================================================
// Module  : div_step
// Purpose : One restoring shift-subtract iteration on the {rem, quo} register.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] work_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [2*WIDTH:0] work_o
);

    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Partial remainder shifted left with the next dividend bit pulled in.
    assign rem_shift = work_i[2*WIDTH:WIDTH-1];
    assign fits      = (rem_shift >= {2'b00, divisor_i});
    assign diff      = rem_shift[WIDTH:0] - {1'b0, divisor_i};

    always_comb begin
        if (fits) begin
            work_o = {diff, work_i[WIDTH-2:0], 1'b1};
        end else begin
            work_o = {rem_shift[WIDTH:0], work_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module  : div_unit
// Purpose : Multi-cycle signed/unsigned divider, result = {remainder, quotient}.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH:0]    work_q, work_d;
    logic [WIDTH-1:0]    divisor_q, divisor_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]  result_q, result_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic [2*WIDTH:0]    step_work;
    logic [WIDTH-1:0]    op1_mag, op2_mag, quo_raw, rem_raw, quo_fix, rem_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (step_work)
    );

    assign op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign quo_raw = step_work[WIDTH-1:0];
    assign rem_raw = step_work[2*WIDTH-1:WIDTH];
    assign quo_fix = neg_quo_q ? -quo_raw : quo_raw;
    assign rem_fix = neg_rem_q ? -rem_raw : rem_raw;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        unique case (state_q)
            DIV_FREE: begin
                if (!annul_i && start_i == DIV_START) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        work_d    = {{(WIDTH+1){1'b0}}, op1_mag};
                        divisor_d = op2_mag;
                        neg_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d = signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    work_d = step_work;
                    cnt_d  = cnt_q + CNT_W'(1);
                    // Last iteration: sign-correct the step output directly.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DIV_END;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (annul_i || start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
        busy_d = (state_d == DIV_ON) || (state_d == DIV_BY_ZERO);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;

endmodule

`default_nettype wire
